// File: rtl/par_task_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : par_task_tracker
//  Description : Launches up to NUM_TASKS parallel countdown timers with one
//                start strobe and reports per-task, first and last completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module par_task_tracker #(
    parameter int  NUM_TASKS = 3,
    parameter int  DLY_W     = 8,
    localparam int ID_W      = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_TASKS-1:0]       task_en,
    input  logic [NUM_TASKS*DLY_W-1:0] dly,
    output logic                       busy,
    output logic [NUM_TASKS-1:0]       task_done,
    output logic                       any_done,
    output logic [ID_W-1:0]            first_id,
    output logic                       all_done,
    output logic [NUM_TASKS-1:0]       done_vec
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                        state_q, state_d;
    logic [NUM_TASKS-1:0][DLY_W-1:0]   cnt_q, cnt_d;
    logic [NUM_TASKS-1:0]              pend_q, pend_d;
    logic [NUM_TASKS-1:0]              done_vec_q, done_vec_d;
    logic                              first_seen_q, first_seen_d;
    logic [ID_W-1:0]                   first_id_q, first_id_d;

    logic                              w_active;
    logic                              w_launch;
    logic                              w_any;
    logic                              w_last;
    logic [NUM_TASKS-1:0]              w_fin;
    logic [ID_W-1:0]                   w_first_idx;

    // State and datapath registers; reset overrides start and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_q       <= '0;
            done_vec_q   <= '0;
            first_seen_q <= 1'b0;
            first_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            done_vec_q   <= done_vec_d;
            first_seen_q <= first_seen_d;
            first_id_q   <= first_id_d;
        end
    end

    // Completion detection; abort masks every completion in its cycle and the
    // descending scan leaves the lowest finishing index in w_first_idx.
    always_comb begin
        w_active    = (state_q == ST_RUN) && !abort;
        w_fin       = '0;
        w_first_idx = '0;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            if (w_active && pend_q[i] && (cnt_q[i] == '0)) begin
                w_fin[i]    = 1'b1;
                w_first_idx = ID_W'(i);
            end
        end
        w_any    = (|w_fin) && !first_seen_q;
        w_last   = (|w_fin) && ((pend_q & ~w_fin) == '0);
        w_launch = (state_q == ST_IDLE) && start && (|task_en);
    end

    // Next-state logic: launch needs at least one enabled task; RUN ends on
    // abort or when the last pending task finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_launch) state_d = ST_RUN;
            ST_RUN:  if (abort || w_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath update: load on launch, count down pending timers in RUN.
    // Counters stop at zero so the maximum delay never wraps.
    always_comb begin
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        done_vec_d   = done_vec_q;
        first_seen_d = first_seen_q;
        first_id_d   = first_id_q;
        if (w_launch) begin
            for (int i = 0; i < NUM_TASKS; i++) begin
                cnt_d[i] = dly[i*DLY_W +: DLY_W];
            end
            pend_d       = task_en;
            done_vec_d   = '0;
            first_seen_d = 1'b0;
            first_id_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (abort) begin
                pend_d = '0;
            end else begin
                for (int i = 0; i < NUM_TASKS; i++) begin
                    if (pend_q[i] && (cnt_q[i] != '0)) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                pend_d     = pend_q & ~w_fin;
                done_vec_d = done_vec_q | w_fin;
                if (w_any) begin
                    first_seen_d = 1'b1;
                    first_id_d   = w_first_idx;
                end
            end
        end
    end

    // Outputs: completion pulses are visible in the completing cycle itself,
    // and everything reads zero while reset is held.
    always_comb begin
        busy      = !rst && (state_q == ST_RUN);
        task_done = rst ? '0 : w_fin;
        any_done  = !rst && w_any;
        all_done  = !rst && w_last;
        done_vec  = rst ? '0 : (done_vec_q | w_fin);
        first_id  = rst ? '0 : (w_any ? w_first_idx : first_id_q);
    end

endmodule
`default_nettype wire

// File: tb/tb_par_task_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_par_task_tracker
//  Description : Self-checking bench for par_task_tracker; a finish-time
//                reference model predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_par_task_tracker;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [N-1:0]   task_en = '0;
    logic [N*W-1:0] dly = '0;
    logic           busy, any_done, all_done;
    logic [N-1:0]   task_done, done_vec;
    logic [IW-1:0]  first_id;
    logic [10:0]    obs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each launched task finishes at launch_cycle + dly + 1.
    bit           m_busy = 1'b0;
    int           m_fin [N];
    logic [N-1:0] m_pend = '0, m_dv = '0;
    bit           m_fs = 1'b0;
    logic [IW-1:0] m_fid = '0;
    logic [N-1:0] e_td, e_dv;
    logic         e_any, e_all, e_busy;
    logic [IW-1:0] e_fid;

    par_task_tracker #(.NUM_TASKS(N), .DLY_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .task_en(task_en), .dly(dly), .busy(busy), .task_done(task_done),
        .any_done(any_done), .first_id(first_id), .all_done(all_done),
        .done_vec(done_vec)
    );

    always #5 clk = ~clk;

    assign obs = {busy, task_done, any_done, first_id, all_done, done_vec};

    function automatic logic [10:0] exp_vec();
        return {e_busy, e_td, e_any, e_fid, e_all, e_dv};
    endfunction

    function automatic logic [N*W-1:0] pack3(input int d0, input int d1, input int d2);
        logic [N*W-1:0] v;
        v = {W'(d2), W'(d1), W'(d0)};
        return v;
    endfunction

    task automatic model_eval();
        e_td = '0; e_any = 1'b0; e_all = 1'b0; e_busy = 1'b0; e_fid = '0; e_dv = '0;
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (m_busy && !abort && m_pend[i] && (m_fin[i] == cyc)) e_td[i] = 1'b1;
            e_any = (e_td != '0) && !m_fs;
            e_fid = m_fid;
            if (e_any) begin
                for (int i = 0; i < N; i++)
                    if (e_td[i]) begin e_fid = IW'(i); break; end
            end
            e_all  = (e_td != '0) && ((m_pend & ~e_td) == '0);
            e_dv   = m_dv | e_td;
            e_busy = m_busy;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = 1'b0; m_pend = '0; m_dv = '0; m_fs = 1'b0; m_fid = '0;
        end else if (!m_busy) begin
            if (start && (task_en != '0)) begin
                m_busy = 1'b1; m_pend = task_en; m_dv = '0; m_fs = 1'b0; m_fid = '0;
                for (int i = 0; i < N; i++) m_fin[i] = cyc + int'(dly[i*W +: W]) + 1;
            end
        end else if (abort) begin
            m_busy = 1'b0; m_pend = '0;
        end else begin
            m_pend = m_pend & ~e_td;
            m_dv   = e_dv;
            if (e_any) begin m_fs = 1'b1; m_fid = e_fid; end
            if (e_all) m_busy = 1'b0;
        end
    endtask

    // Drive one cycle's inputs and compute the model prediction at mid-cycle.
    task automatic apply(input logic st, input logic ab, input logic rs,
                         input logic [N-1:0] en, input logic [N*W-1:0] d);
        start = st; abort = ab; rst = rs; task_en = en; dly = d;
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 1'b1, '0, '0);
            checks++;
            if (obs !== 11'd0) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs, 11'd0); end
            advance();
        end
        apply(1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_release got=%b exp=%b", obs, exp_vec()); end
        advance();
    endtask

    task automatic test_launch();
        for (int r = 0; r <= 34; r++) begin
            apply(r == 0, 1'b0, 1'b0, 3'b111, pack3(30, 15, 10));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL launch r=%0d got=%b exp=%b", r, obs, exp_vec()); end
            if (r == 11) begin
                checks++;
                if ({task_done, any_done, first_id} !== {3'b100, 1'b1, 2'd2}) begin
                    errors++; $display("FAIL launch_first got=%b exp=%b", {task_done, any_done, first_id}, {3'b100, 1'b1, 2'd2});
                end
            end
            if (r == 31) begin
                checks++;
                if ({task_done, all_done} !== {3'b001, 1'b1}) begin
                    errors++; $display("FAIL launch_last got=%b exp=%b", {task_done, all_done}, {3'b001, 1'b1});
                end
            end
            if (r == 32) begin
                checks++;
                if ({busy, done_vec} !== {1'b0, 3'b111}) begin
                    errors++; $display("FAIL launch_end got=%b exp=%b", {busy, done_vec}, {1'b0, 3'b111});
                end
            end
            advance();
        end
    endtask

    task automatic test_tie();
        for (int r = 0; r <= 23; r++) begin
            apply(r == 0, 1'b0, 1'b0, 3'b111, pack3(5, 5, 20));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tie r=%0d got=%b exp=%b", r, obs, exp_vec()); end
            if (r == 6) begin
                checks++;
                if ({task_done, any_done, first_id} !== {3'b011, 1'b1, 2'd0}) begin
                    errors++; $display("FAIL tie_first got=%b exp=%b", {task_done, any_done, first_id}, {3'b011, 1'b1, 2'd0});
                end
            end
            if (r == 21) begin
                checks++;
                if (all_done !== 1'b1) begin errors++; $display("FAIL tie_all got=%b exp=1", all_done); end
            end
            advance();
        end
    endtask

    task automatic test_mask();
        for (int r = 0; r <= 7; r++) begin
            apply(r == 0 || r == 4, 1'b0, 1'b0, (r == 4) ? 3'b000 : 3'b010, pack3(9, 0, 9));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL mask r=%0d got=%b exp=%b", r, obs, exp_vec()); end
            if (r == 1) begin
                checks++;
                if ({task_done, any_done, all_done, first_id} !== {3'b010, 1'b1, 1'b1, 2'd1}) begin
                    errors++; $display("FAIL mask_single got=%b exp=%b", {task_done, any_done, all_done, first_id}, {3'b010, 1'b1, 1'b1, 2'd1});
                end
            end
            if (r == 2 || r == 5) begin
                checks++;
                if ({busy, task_done} !== 4'b0) begin errors++; $display("FAIL mask_idle r=%0d got=%b exp=0000", r, {busy, task_done}); end
            end
            advance();
        end
    endtask

    task automatic test_abort();
        int n_all = 0;
        for (int r = 0; r <= 35; r++) begin
            apply(r == 0 || r == 9, r == 12, 1'b0, 3'b111, (r == 9) ? pack3(1, 1, 1) : pack3(30, 15, 10));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL abort r=%0d got=%b exp=%b", r, obs, exp_vec()); end
            if (all_done) n_all++;
            if (r == 11) begin
                checks++;
                if (task_done !== 3'b100) begin errors++; $display("FAIL abort_t2 got=%b exp=100", task_done); end
            end
            if (r == 13) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
            end
            advance();
        end
        checks++;
        if (n_all != 0 || done_vec !== 3'b100) begin
            errors++; $display("FAIL abort_final all_done_count=%0d done_vec=%b exp 0/100", n_all, done_vec);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int r = 0; r <= 22; r++) begin
            apply(r == 0 || r == 8, 1'b0, r == 5, 3'b111, pack3(30, 15, 10));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rstrun r=%0d got=%b exp=%b", r, obs, exp_vec()); end
            if (r == 6) begin
                checks++;
                if (obs !== 11'd0) begin errors++; $display("FAIL rstrun_clear got=%b exp=0", obs); end
            end
            if (r == 19) begin
                checks++;
                if (any_done !== 1'b1) begin errors++; $display("FAIL rstrun_relaunch got=%b exp=1", any_done); end
            end
            advance();
        end
        for (int r = 0; r < 25; r++) begin
            apply(1'b0, 1'b0, 1'b0, '0, '0);
            advance();
        end
    endtask

    task automatic test_random();
        logic [N*W-1:0] d;
        for (int r = 0; r < 3000; r++) begin
            for (int i = 0; i < N; i++)
                d[i*W +: W] = ($urandom_range(0, 20) == 0) ? 8'hFF : W'($urandom_range(0, 20));
            apply($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 120) == 0,
                  N'($urandom_range(0, 7)), d);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random r=%0d got=%b exp=%b", r, obs, exp_vec()); end
            advance();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_launch();
        test_tie();
        test_mask();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
